// File: rtl/laplacian_sharpen_param.sv
// 3x3 Laplacian luma sharpening (4/8-neighbour, Q2.2 gain) with delay-matched chroma and video strobes.
// Optional build macro LAP_SHARPEN_BORDER_BYPASS_EN: border pixels pass the input luma through unfiltered.
module laplacian_sharpen_param #(
  parameter int DW    = 8,
  parameter int IMG_W = 640
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            per_img_vsync,
  input  logic            per_img_href,
  input  logic            per_img_clken,
  input  logic [3*DW-1:0] per_img_data,
  input  logic            cfg_mode,
  input  logic [3:0]      cfg_gain,
  output logic            post_img_vsync,
  output logic            post_img_href,
  output logic            post_img_clken,
  output logic [3*DW-1:0] post_img_data
);
  localparam int CW = $clog2(IMG_W);
  localparam logic signed [DW+7:0] Y_MAX = (DW+8)'((1 << DW) - 1);

  typedef enum logic {WAIT_FRAME, ACTIVE} state_t;
  state_t state_reg;

  logic            vsync_d_reg, href_d_reg;
  logic [CW-1:0]   col_reg;
  logic            col_full_reg;
  logic [15:0]     row_reg;
  logic            cfg_mode_reg;
  logic [3:0]      cfg_gain_reg;
  logic            vs_rise, href_fall, oob, first_px;
  logic [CW-1:0]   col_eff, addr;
  logic [15:0]     row_eff;
  logic [DW-1:0]   y_in;
  logic [3:0]      vs_sr_reg, hs_sr_reg, ce_sr_reg;

  assign y_in      = per_img_data[3*DW-1:2*DW];
  assign vs_rise   = per_img_vsync & ~vsync_d_reg;
  assign href_fall = ~per_img_href & href_d_reg;
  // A vsync edge clears the position in its own cycle, so a coincident pixel is (0,0).
  assign col_eff   = vs_rise ? '0 : col_reg;
  assign row_eff   = vs_rise ? '0 : row_reg;
  assign oob       = (~vs_rise & col_full_reg) | ({1'b0, col_eff} >= (CW+1)'(IMG_W));
  assign first_px  = (col_eff == '0) & ~oob;
  assign addr      = oob ? '0 : col_eff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= WAIT_FRAME;
      ce_sr_reg <= '0;
    end else begin
      case (state_reg)
        WAIT_FRAME: if (vs_rise) state_reg <= ACTIVE;
        default:    state_reg <= ACTIVE;
      endcase
      ce_sr_reg <= {ce_sr_reg[2:0], per_img_clken & ((state_reg == ACTIVE) | vs_rise)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d_reg  <= 1'b0;
      href_d_reg   <= 1'b0;
      col_reg      <= '0;
      col_full_reg <= 1'b0;
      row_reg      <= '0;
      cfg_mode_reg <= 1'b0;
      cfg_gain_reg <= 4'd4;
    end else begin
      vsync_d_reg <= per_img_vsync;
      href_d_reg  <= per_img_href;
      if (vs_rise) begin
        row_reg      <= '0;
        col_reg      <= per_img_clken ? CW'(1) : '0;
        col_full_reg <= 1'b0;
        cfg_mode_reg <= cfg_mode;
        cfg_gain_reg <= cfg_gain;
      end else if (href_fall) begin
        row_reg      <= row_reg + 16'd1;
        col_reg      <= '0;
        col_full_reg <= 1'b0;
      end else if (per_img_clken) begin
        col_reg <= col_reg + CW'(1);
        if (col_reg == CW'(IMG_W - 1)) col_full_reg <= 1'b1;
      end
    end
  end

  // Line buffers: read-before-write, so lb1 shifts its old row into lb2.
  logic [DW-1:0] lb1 [IMG_W];
  logic [DW-1:0] lb2 [IMG_W];
  logic [DW-1:0] top_rd_reg, mid_rd_reg;

  always_ff @(posedge clk) begin
    if (per_img_clken) begin
      top_rd_reg <= lb2[addr];
      mid_rd_reg <= lb1[addr];
      if (!oob) begin
        lb1[addr] <= y_in;
        lb2[addr] <= lb1[addr];
      end
    end
  end

  logic [DW-1:0] y_q_reg;
  logic          top_ok_reg, mid_ok_reg, bot_ok_reg;
  logic [DW-1:0] new_col [3];
  logic [DW-1:0] win0_reg [3];
  logic [DW-1:0] win1_reg [3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q_reg    <= '0;
      top_ok_reg <= 1'b0;
      mid_ok_reg <= 1'b0;
      bot_ok_reg <= 1'b0;
    end else if (per_img_clken) begin
      y_q_reg    <= y_in;
      top_ok_reg <= ~oob & (row_eff >= 16'd2);
      mid_ok_reg <= ~oob & (row_eff >= 16'd1);
      bot_ok_reg <= ~oob;
    end
  end

  always_comb begin
    new_col[0] = top_ok_reg ? top_rd_reg : '0;
    new_col[1] = mid_ok_reg ? mid_rd_reg : '0;
    new_col[2] = bot_ok_reg ? y_q_reg    : '0;
  end

  // Older columns are zeroed at the first pixel of a line so no taps leak across lines.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_win
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          win0_reg[gi] <= '0;
          win1_reg[gi] <= '0;
        end else if (per_img_clken) begin
          win0_reg[gi] <= first_px ? '0 : win1_reg[gi];
          win1_reg[gi] <= first_px ? '0 : new_col[gi];
        end
      end
    end
  endgenerate

  logic [DW+3:0]        sum4, sum8;
  logic signed [DW+3:0] lap4, lap8, lap_reg;
  logic signed [DW+7:0] prod_reg, shifted, y_sum;
  logic [DW-1:0]        p22_d2_reg, p22_d3_reg, y_out_reg, y_clip;

  always_comb begin
    sum4 = {4'b0, win1_reg[0]} + {4'b0, win0_reg[1]} + {4'b0, new_col[1]} + {4'b0, win1_reg[2]};
    sum8 = sum4 + {4'b0, win0_reg[0]} + {4'b0, win0_reg[2]} + {4'b0, new_col[0]} + {4'b0, new_col[2]};
    lap4 = $signed({2'b0, win1_reg[1], 2'b0}) - $signed(sum4);
    lap8 = $signed({1'b0, win1_reg[1], 3'b0}) - $signed(sum8);
  end

  always_comb begin
    shifted = prod_reg >>> 2;
    y_sum   = $signed({8'b0, p22_d3_reg}) + shifted;
    if (y_sum < 0)          y_clip = '0;
    else if (y_sum > Y_MAX) y_clip = '1;
    else                    y_clip = y_sum[DW-1:0];
  end

`ifdef LAP_SHARPEN_BORDER_BYPASS_EN
  logic border_reg, border_d2_reg, border_d3_reg;
  logic [DW-1:0] byp_d2_reg, byp_d3_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      border_reg    <= 1'b0;
      border_d2_reg <= 1'b0;
      border_d3_reg <= 1'b0;
      byp_d2_reg    <= '0;
      byp_d3_reg    <= '0;
    end else begin
      if (per_img_clken) border_reg <= oob | (row_eff < 16'd2) | (col_eff < CW'(2));
      border_d2_reg <= border_reg;
      border_d3_reg <= border_d2_reg;
      byp_d2_reg    <= y_q_reg;
      byp_d3_reg    <= byp_d2_reg;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_reg    <= '0;
      p22_d2_reg <= '0;
      prod_reg   <= '0;
      p22_d3_reg <= '0;
      y_out_reg  <= '0;
    end else begin
      lap_reg    <= cfg_mode_reg ? lap8 : lap4;
      p22_d2_reg <= win1_reg[1];
      prod_reg   <= $signed({{4{lap_reg[DW+3]}}, lap_reg}) * $signed({{(DW+4){1'b0}}, cfg_gain_reg});
      p22_d3_reg <= p22_d2_reg;
`ifdef LAP_SHARPEN_BORDER_BYPASS_EN
      y_out_reg  <= border_d3_reg ? byp_d3_reg : y_clip;
`else
      y_out_reg  <= y_clip;
`endif
    end
  end

  logic [2*DW-1:0] chroma_sr_reg [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_chroma
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chroma_sr_reg[gi] <= '0;
        else if (gi == 0) chroma_sr_reg[gi] <= per_img_data[2*DW-1:0];
        else chroma_sr_reg[gi] <= chroma_sr_reg[(gi == 0) ? 0 : gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_sr_reg <= '0;
      hs_sr_reg <= '0;
    end else begin
      vs_sr_reg <= {vs_sr_reg[2:0], per_img_vsync};
      hs_sr_reg <= {hs_sr_reg[2:0], per_img_href};
    end
  end

  assign post_img_vsync = vs_sr_reg[3];
  assign post_img_href  = hs_sr_reg[3];
  assign post_img_clken = ce_sr_reg[3];
  assign post_img_data  = {y_out_reg, chroma_sr_reg[3]};

endmodule

// File: tb/tb_laplacian_sharpen_param.sv
// Randomised frame bench for laplacian_sharpen_param against a zero-padded 3x3 window reference model.
// Builds with or without LAP_SHARPEN_BORDER_BYPASS_EN, matching the design build.
module tb_laplacian_sharpen_param;
  localparam int DW    = 8;
  localparam int IMG_W = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        per_img_vsync = 1'b0, per_img_href = 1'b0, per_img_clken = 1'b0;
  logic [23:0] per_img_data = '0;
  logic        cfg_mode = 1'b0;
  logic [3:0]  cfg_gain = 4'd4;
  logic        post_img_vsync, post_img_href, post_img_clken;
  logic [23:0] post_img_data;

  laplacian_sharpen_param #(.DW(DW), .IMG_W(IMG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .per_img_vsync(per_img_vsync), .per_img_href(per_img_href),
    .per_img_clken(per_img_clken), .per_img_data(per_img_data),
    .cfg_mode(cfg_mode), .cfg_gain(cfg_gain),
    .post_img_vsync(post_img_vsync), .post_img_href(post_img_href),
    .post_img_clken(post_img_clken), .post_img_data(post_img_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  int img [0:9][0:19];
  int cur_r = 0, cur_c = 0;
  int cap_mode = 0, cap_gain = 4;
  bit armed = 0, prev_vs = 0;

  typedef struct {
    logic        vs, hs, ce;
    logic [7:0]  y;
    logic [15:0] cc;
  } rec_t;
  rec_t q[$];

  function automatic int tap(int r, int c);
    if (r < 0 || c < 0 || c >= IMG_W) return 0;
    return img[r][c];
  endfunction

  // Output (r,c) is the filtered centre (r-1,c-1).
  function automatic int model_y(int r, int c);
    int ctr, s4, s8, lap, p, s, y;
`ifdef LAP_SHARPEN_BORDER_BYPASS_EN
    if (r < 2 || c < 2 || c >= IMG_W) return img[r][c];
`endif
    ctr = tap(r-1, c-1);
    s4  = tap(r-2, c-1) + tap(r-1, c-2) + tap(r-1, c) + tap(r, c-1);
    s8  = s4 + tap(r-2, c-2) + tap(r-2, c) + tap(r, c-2) + tap(r, c);
    lap = (cap_mode != 0) ? 8*ctr - s8 : 4*ctr - s4;
    p   = lap * cap_gain;
    s   = (p >= 0) ? p / 4 : -((-p + 3) / 4);
    y   = ctr + s;
    if (y < 0) y = 0;
    if (y > 255) y = 255;
    return y;
  endfunction

  always @(negedge clk) begin
    rec_t rec, e;
    bit   vs_rise;
    if (!rst_n) begin
      check_val("reset_outputs", {5'b0, post_img_vsync, post_img_href, post_img_clken, post_img_data}, 32'd0);
      q.delete();
      rec = '{1'b0, 1'b0, 1'b0, 8'd0, 16'd0};
      repeat (4) q.push_back(rec);
      armed   = 0;
      prev_vs = 0;
    end else begin
      vs_rise = per_img_vsync && !prev_vs;
      prev_vs = per_img_vsync;
      if (vs_rise) begin
        cap_mode = int'(cfg_mode);
        cap_gain = int'(cfg_gain);
        armed    = 1;
      end
      rec.vs = per_img_vsync;
      rec.hs = per_img_href;
      rec.ce = per_img_clken && armed;
      rec.y  = rec.ce ? 8'(model_y(cur_r, cur_c)) : 8'd0;
      rec.cc = per_img_data[15:0];
      q.push_back(rec);
      e = q.pop_front();
      check_val("strobes", {29'b0, post_img_vsync, post_img_href, post_img_clken}, {29'b0, e.vs, e.hs, e.ce});
      if (e.ce) begin
        check_val("luma", {24'b0, post_img_data[23:16]}, {24'b0, e.y});
        check_val("chroma", {16'b0, post_img_data[15:0]}, {16'b0, e.cc});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    per_img_vsync = 1'b0;
    per_img_href  = 1'b0;
    per_img_clken = 1'b0;
    repeat (n) tick();
  endtask

  task automatic put_px(input int r, input int c);
    logic [31:0] rnd;
    rnd = $urandom();
    per_img_clken = 1'b1;
    per_img_data  = {8'(img[r][c]), rnd[15:0]};
    cur_r = r;
    cur_c = c;
    tick();
    per_img_clken = 1'b0;
  endtask

  int frame_no = 0;

  task automatic send_frame(input int kind, input int w, input int h, input int mode, input int gain,
                            input bit gaps, input bit vs_px, input int rst_row, input int gchg_row);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        case (kind)
          0: img[r][c] = 100;
          1: img[r][c] = (r == 4 && c == 4) ? 200 : 0;
          2: img[r][c] = (r == 4 && c == 4) ? 10 : 0;
          3: img[r][c] = (r*20 + c*12) % 256;
          default: img[r][c] = int'($urandom_range(0, 255));
        endcase
    cfg_mode = mode[0];
    cfg_gain = 4'(gain);
    if (!vs_px) begin
      per_img_vsync = 1'b1;
      tick();
      tick();
      idle(3);
    end
    for (int r = 0; r < h; r++) begin
      per_img_href = 1'b1;
      for (int c = 0; c < w; c++) begin
        if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) tick();
        if (vs_px && r == 0 && c == 0) per_img_vsync = 1'b1;
        put_px(r, c);
        per_img_vsync = 1'b0;
        if (r == rst_row && c == 5) begin
          rst_n = 1'b0;
          repeat (3) tick();
          rst_n = 1'b1;
        end
      end
      idle(3);
      if (r == gchg_row) cfg_gain = 4'(gain + 5);
    end
    idle(8);
    frame_no++;
    $display("frame %0d kind=%0d size=%0dx%0d mode=%0d gain=%0d checks=%0d errors=%0d",
             frame_no, kind, w, h, mode, gain, n_checks, n_errors);
  endtask

  initial begin
    repeat (4) tick();
    rst_n = 1'b1;
    idle(3);
    send_frame(0, 16, 8, 0, 4, 0, 0, -1, -1);  // flat field
    send_frame(1, 16, 8, 0, 4, 0, 0, -1, -1);  // impulse, 4-neighbour
    send_frame(2, 16, 8, 1, 4, 0, 0, -1, -1);  // impulse, 8-neighbour
    send_frame(2, 16, 8, 1, 0, 1, 0, -1, -1);  // gain 0 identity
    send_frame(3, 18, 8, 0, 4, 1, 0, -1, -1);  // ramp wider than the line buffer
    send_frame(3, 16, 8, 1, 9, 1, 1, -1, -1);  // vsync coincident with first pixel
    send_frame(4, 16, 8, 0, 6, 1, 0, -1, 3);   // gain changed mid-frame
    send_frame(4, 16, 8, 0, 11, 1, 0, -1, -1);
    send_frame(4, 16, 8, 1, 5, 1, 0, 3, -1);   // reset at row 3
    send_frame(4, 16, 8, 1, 7, 1, 0, -1, -1);
    for (int i = 0; i < 4; i++)
      send_frame(3 + int'($urandom_range(0, 1)), 16 + 2*int'($urandom_range(0, 1)), 8,
                 int'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 1, i[0], -1, -1);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/laplacian_sharpen_param.md
# laplacian_sharpen_param

Parametrised Laplacian sharpening stage for the ISP YCbCr pipeline, placed after colour conversion and before the HDMI output path. It builds a 3x3 luma window from its own line buffers, applies a selectable 4- or 8-neighbour Laplacian with a per-frame programmable gain, clips the result and re-attaches the chroma of the same pixel. All video strobes are delay-matched.

## Interface
- DW, 8, bits per channel (luma and each chroma channel)
- IMG_W, 640, maximum active pixels per line; sets line-buffer depth
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- per_img_vsync  in  1  input frame sync, active high
- per_img_href  in  1  input line valid
- per_img_clken  in  1  input pixel valid
- per_img_data  in  3*DW  {Y, Cb, Cr}, with Y in the MSBs
- cfg_mode  in  1  0 = 4-neighbour kernel, 1 = 8-neighbour kernel
- cfg_gain  in  4  unsigned Q2.2 sharpening gain (0..3.75)
- post_img_vsync  out  1  delayed vsync
- post_img_href  out  1  delayed href
- post_img_clken  out  1  delayed clken
- post_img_data  out  3*DW  {Y', Cb, Cr}

## Operation
- **Control FSM**
  - WAIT_FRAME (entered on reset): post_img_clken is forced to 0; vsync and href are still forwarded.
  - Rising edge of per_img_vsync moves the FSM to ACTIVE.
  - ACTIVE stays active until reset.
- **Config sampling:** cfg_mode and cfg_gain are sampled on every per_img_vsync rising edge. They are constant for the whole frame.
- **Counters**
  - col: clog2(IMG_W) bits. Increments on per_img_clken. Clears on href falling edge.
  - row: 16 bits. Increments on href falling edge. Clears on vsync rising edge.
- **Line buffers**
  - Two DW x IMG_W buffers, written at address col on per_img_clken.
  - Pixels with col >= IMG_W are not written.
  - Those pixels read as 0 and are treated as border.
- **Window**
  - The 3x3 window shifts on per_img_clken. The newest column is the current input (row r, col c).
  - Output pixel (r,c) therefore carries the filtered centre (r-1, c-1).
  - Border means r < 2 or c < 2 or c >= IMG_W. Taps outside the frame read 0.
- **Arithmetic** (signed, no overflow)
  - lap4 = 4*p22 - (p12+p21+p23+p32), width DW+3.
  - lap8 = 8*p22 - sum of the 8 neighbours, width DW+4.
  - prod = lap * cfg_gain, width DW+8. Then shift: s = prod >>> 2 (arithmetic, floor).
  - y = p22 + s, saturated to [0, 2^DW-1].
  - cfg_gain = 4 with cfg_mode = 0 gives exactly 5*p22 - sum4.
- **Chroma:** Cb and Cr of input (r,c) are delayed through a per-clk shift register aligned to Y'.

## Timing
- Every pipeline stage advances on every clk; clken only qualifies data.
- Pipeline stages:
  - T+1: window register loads.
  - T+2: lap sum.
  - T+3: gain multiply.
  - T+4: add, clip and output register.
- Latency from input strobe to output strobe is exactly 4 clk for vsync, href and clken. Data is valid in the same cycle as post_img_clken.
- Reset values: all outputs 0, FSM = WAIT_FRAME, counters 0, config = {mode 0, gain 4}. Line-buffer contents are don't-care, because border masking covers them.
- Reset asserted mid-frame: outputs go to 0 immediately. The partial frame is discarded, and no post_img_clken is produced until the next vsync rising edge plus 4 clk.
- Back-to-back clken with no gaps is supported. Gaps in clken do not disturb the window.
- vsync rising edge in the same cycle as clken: the counter clears first, so that pixel is counted as row 0.

## Configuration
- Macro: LAP_SHARPEN_BORDER_BYPASS_EN.
- Defined: border pixels output Y' = Y of the same-position input pixel (r,c), unfiltered.
- Undefined: border pixels are filtered using zero-valued out-of-frame taps.

## Test plan
- **Flat field:** 16x8 frame, Y = 100, mode 0, gain 4 -> every interior Y' = 100 and Cb/Cr unchanged.
- **Impulse, 4-neighbour:** Y = 200 at (4,4), background 0, mode 0, gain 4 -> output (5,5) = 255 (clipped); outputs (4,5), (5,4), (6,5), (5,6) = 0.
- **Impulse, 8-neighbour:** Y = 10 at (4,4), mode 1, gain 4 -> output (5,5) = 90; all 8 neighbours = 0. Repeat with gain 0 -> output (5,5) = 10 (identity).
- **Latency:** random clken gaps -> post strobes equal the input strobes delayed by exactly 4 clk, and the Cb/Cr order matches the input.
- **Border with macro:** ramp image with LAP_SHARPEN_BORDER_BYPASS_EN -> rows 0-1 and cols 0-1 output the unfiltered input Y. Without the macro -> the values match the zero-padded reference model.
- **Reset and config mid-frame:**
  - Assert rst_n low at row 3 -> outputs are 0 and post_img_clken stays 0 until the next vsync.
  - Change cfg_gain mid-frame -> the new gain takes effect only from the next frame.
